// File: rtl/perceptron_unit.sv
// perceptron_unit: single trainable neuron, y = act(b + sum w_i*x_i), with combinational
// backprop delta and one SGD step per clock edge while training.
package Common;
    typedef enum logic [1:0] {Sigmoid, ReLU, Tanh, Identity} act_func;
endpackage

module perceptron_unit
    import Common::*;
#(
    parameter int input_units  = 2,
    parameter int output_units = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  real     values [input_units],
    input  act_func activation,
    input  logic    training,
    input  real     learning_rate,
    input  real     next_layer_weights [output_units],
    input  real     error_gradient_next_layer [output_units],
    output real     prediction,
    output real     error_gradient,
    output real     current_weights [input_units]
);
    real w_q [input_units];
    real w_d [input_units];
    real b_q, b_d;
    real z, y, dact, back, delta;

    always_comb begin
        z = b_q;
        for (int i = 0; i < input_units; i++) z = z + w_q[i] * values[i];
        y = activation == Sigmoid ? 1.0 / (1.0 + $exp(-z)) :
            activation == ReLU    ? (z > 0.0 ? z : 0.0) :
            activation == Tanh    ? $tanh(z) : z;
        dact = activation == Sigmoid ? y * (1.0 - y) :
               activation == ReLU    ? (z > 0.0 ? 1.0 : 0.0) :
               activation == Tanh    ? 1.0 - y * y : 1.0;
        back = 0.0;
        for (int k = 0; k < output_units; k++) back = back + next_layer_weights[k] * error_gradient_next_layer[k];
        delta = dact * back;
        prediction = y;
        error_gradient = delta;
    end

    // The step uses the x and delta present before the edge, so it is taken combinationally here
    always_comb begin
        for (int i = 0; i < input_units; i++)
            w_d[i] = training ? w_q[i] - learning_rate * delta * values[i] : w_q[i];
        b_d = training ? b_q - learning_rate * delta : b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < input_units; i++) w_q[i] <= 0.1;
            b_q <= 0.0;
        end else begin
            for (int i = 0; i < input_units; i++) w_q[i] <= w_d[i];
            b_q <= b_d;
        end
    end

    always_comb begin
        for (int i = 0; i < input_units; i++) current_weights[i] = w_q[i];
    end
endmodule

// File: tb/tb_perceptron_unit.sv
// tb_perceptron_unit: directed tests of the perceptron forward pass, backprop delta,
// SGD update, reset priority, AND-gate training and the activation variants.
module tb_perceptron_unit;
    import Common::*;

    localparam real TOL = 1e-5;
    localparam real EPS = 1e-7;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    real     x [2];
    act_func act = Sigmoid;
    logic    training = 1'b0;
    real     lr = 0.0;
    real     v [1];
    real     g [1];
    real     prediction, error_gradient;
    real     cw [2];
    int      vectors = 0;
    int      miscompares = 0;

    perceptron_unit #(.input_units(2), .output_units(1)) dut (
        .clk(clk), .rst(rst), .values(x), .activation(act), .training(training),
        .learning_rate(lr), .next_layer_weights(v), .error_gradient_next_layer(g),
        .prediction(prediction), .error_gradient(error_gradient), .current_weights(cw)
    );

    always #5 clk = ~clk;

    function automatic real rabs(input real a);
        return a < 0.0 ? -a : a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        training = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        x[0] = 0.0; x[1] = 0.0; act = Sigmoid; v[0] = 1.0; g[0] = 1.0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] - 0.1) > TOL) begin
                miscompares++;
                $display("FAIL reset_w%0d: got %f expected %f", i, cw[i], 0.1);
            end
        end
        vectors++;
        if (rabs(prediction - 0.5) > TOL) begin
            miscompares++;
            $display("FAIL reset_pred: got %f expected %f", prediction, 0.5);
        end
    endtask

    task automatic test_forward();
        x[0] = 1.0; x[1] = 1.0; act = Sigmoid; training = 1'b0;
        #1;
        vectors++;
        if (rabs(prediction - 0.549834) > TOL) begin
            miscompares++;
            $display("FAIL fwd_pred: got %f expected %f", prediction, 0.549834);
        end
        repeat (5) step();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] - 0.1) > TOL) begin
                miscompares++;
                $display("FAIL fwd_hold_w%0d: got %f expected %f", i, cw[i], 0.1);
            end
        end
    endtask

    task automatic test_single_step();
        x[0] = 1.0; x[1] = 1.0; act = Sigmoid; lr = 1.0; v[0] = 1.0; g[0] = 1.0;
        training = 1'b1;
        #1;
        vectors++;
        if (rabs(error_gradient - 0.247517) > TOL) begin
            miscompares++;
            $display("FAIL step_delta: got %f expected %f", error_gradient, 0.247517);
        end
        step();
        training = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] + 0.147517) > TOL) begin
                miscompares++;
                $display("FAIL step_w%0d: got %f expected %f", i, cw[i], -0.147517);
            end
        end
        // Identity with zero inputs exposes the bias on the prediction
        act = Identity; x[0] = 0.0; x[1] = 0.0;
        #1;
        vectors++;
        if (rabs(prediction + 0.247517) > TOL) begin
            miscompares++;
            $display("FAIL step_bias: got %f expected %f", prediction, -0.247517);
        end
    endtask

    task automatic test_reset_priority();
        act = Sigmoid; x[0] = 1.0; x[1] = 1.0; lr = 1.0; v[0] = 1.0; g[0] = 1.0;
        training = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1; training = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] - 0.1) > TOL) begin
                miscompares++;
                $display("FAIL prio_w%0d: got %f expected %f", i, cw[i], 0.1);
            end
        end
        act = Identity; x[0] = 0.0; x[1] = 0.0;
        #1;
        vectors++;
        if (rabs(prediction) > TOL) begin
            miscompares++;
            $display("FAIL prio_bias: got %f expected %f", prediction, 0.0);
        end
    endtask

    task automatic test_zero_input_step();
        // x=0: weights hold while the bias still steps by -lr*delta (identity, delta = 0.5)
        act = Identity; x[0] = 0.0; x[1] = 0.0; lr = 0.5; v[0] = 1.0; g[0] = 0.5;
        training = 1'b1;
        step();
        training = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] - 0.1) > TOL) begin
                miscompares++;
                $display("FAIL zx_w%0d: got %f expected %f", i, cw[i], 0.1);
            end
        end
        #1;
        vectors++;
        if (rabs(prediction + 0.25) > TOL) begin
            miscompares++;
            $display("FAIL zx_bias: got %f expected %f", prediction, -0.25);
        end
        do_reset();
    endtask

    task automatic test_and_gate();
        real mw [2];
        real mb, ym, cost, prev_cost, md;
        int  t;
        mw[0] = 0.1; mw[1] = 0.1; mb = 0.0; prev_cost = 0.0;
        act = Sigmoid; lr = 1.0; v[0] = 1.0;
        for (int e = 0; e < 10; e++) begin
            cost = 0.0;
            for (int p = 0; p < 4; p++) begin
                x[0] = real'(p >> 1); x[1] = real'(p & 1); t = (p == 3) ? 1 : 0;
                ym = 1.0 / (1.0 + $exp(-(mb + mw[0] * x[0] + mw[1] * x[1])));
                g[0] = -(real'(t) / (ym + EPS) - real'(1 - t) / (1.0 - ym + EPS));
                cost = cost - (real'(t) * $ln(ym + EPS) + real'(1 - t) * $ln(1.0 - ym + EPS));
                md = ym * (1.0 - ym) * g[0];
                training = 1'b1;
                #1;
                vectors++;
                if (rabs(prediction - ym) > TOL) begin
                    miscompares++;
                    $display("FAIL and_pred e%0d p%0d: got %f expected %f", e, p, prediction, ym);
                end
                mw[0] = mw[0] - lr * md * x[0];
                mw[1] = mw[1] - lr * md * x[1];
                mb = mb - lr * md;
                step();
            end
            if (e > 0) begin
                vectors++;
                if (cost >= prev_cost) begin
                    miscompares++;
                    $display("FAIL and_cost e%0d: got %f expected below %f", e, cost, prev_cost);
                end
            end
            prev_cost = cost;
        end
        training = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] - mw[i]) > TOL) begin
                miscompares++;
                $display("FAIL and_w%0d: got %f expected %f", i, cw[i], mw[i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            x[0] = real'(p >> 1); x[1] = real'(p & 1);
            #1;
            vectors++;
            if ((prediction >= 0.5) != (p == 3)) begin
                miscompares++;
                $display("FAIL and_class p%0d: got %f expected %s 0.5", p, prediction, p == 3 ? ">=" : "<");
            end
        end
        do_reset();
    endtask

    task automatic test_activations();
        x[0] = 1.0; x[1] = 1.0; v[0] = 2.0; g[0] = 0.5; training = 1'b0;
        act = ReLU;
        #1;
        vectors++;
        if (rabs(prediction - 0.2) > TOL) begin
            miscompares++;
            $display("FAIL relu_pred: got %f expected %f", prediction, 0.2);
        end
        vectors++;
        if (rabs(error_gradient - 1.0) > TOL) begin
            miscompares++;
            $display("FAIL relu_delta: got %f expected %f", error_gradient, 1.0);
        end
        act = Tanh;
        #1;
        vectors++;
        if (rabs(prediction - 0.197375) > TOL) begin
            miscompares++;
            $display("FAIL tanh_pred: got %f expected %f", prediction, 0.197375);
        end
        vectors++;
        if (rabs(error_gradient - 0.961043) > TOL) begin
            miscompares++;
            $display("FAIL tanh_delta: got %f expected %f", error_gradient, 0.961043);
        end
        act = Identity;
        #1;
        vectors++;
        if (rabs(prediction - 0.2) > TOL || rabs(error_gradient - 1.0) > TOL) begin
            miscompares++;
            $display("FAIL ident: got y=%f d=%f expected y=%f d=%f", prediction, error_gradient, 0.2, 1.0);
        end
        act = ReLU; x[0] = -5.0; x[1] = -5.0;
        #1;
        vectors++;
        if (rabs(prediction) > TOL || rabs(error_gradient) > TOL) begin
            miscompares++;
            $display("FAIL relu_neg: got y=%f d=%f expected y=%f d=%f", prediction, error_gradient, 0.0, 0.0);
        end
    endtask

    task automatic test_back_to_back();
        // Two identity steps with x=[1,1], lr=0.1, v*g=1: each edge moves w and b by -0.1
        act = Identity; x[0] = 1.0; x[1] = 1.0; lr = 0.1; v[0] = 1.0; g[0] = 1.0;
        training = 1'b1;
        step();
        step();
        training = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rabs(cw[i] + 0.1) > TOL) begin
                miscompares++;
                $display("FAIL b2b_w%0d: got %f expected %f", i, cw[i], -0.1);
            end
        end
        vectors++;
        if (rabs(prediction + 0.4) > TOL) begin
            miscompares++;
            $display("FAIL b2b_pred: got %f expected %f", prediction, -0.4);
        end
    endtask

    initial begin
        x[0] = 0.0; x[1] = 0.0; v[0] = 1.0; g[0] = 1.0;
        test_reset();
        test_forward();
        test_single_step();
        test_reset_priority();
        test_zero_input_step();
        test_and_gate();
        test_activations();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
